serial_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver used on the Fomu builds. It adds configurable data width, optional parity, one or two stop bits and 3-sample majority voting. It reports framing, parity, break and overrun status. Received words are presented through a one-entry holding register with a valid/ready handshake toward the consumer (FIFO or command decoder).

---
 rtl/serial_rx_cfg.sv | 175 +++++++++++++++++
 tb/tb_serial_rx_cfg.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_cfg.sv
`timescale 1ns/1ps
// Parametrised UART receiver: 5..9 data bits, optional parity, one or two stop bits,
// 3-sample majority voting, break/overrun reporting and a one-entry valid/ready holder.
module serial_rx_cfg #(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_break,
    output logic                 o_overrun
);
    localparam int BAUD_CLKS = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W     = $clog2(BAUD_CLKS);
    localparam int IDX_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(BAUD_CLKS >> 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(BAUD_CLKS - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_BRKWAIT
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 pbit;
    logic                 perr;
    logic                 ferr;
    logic [1:0]           sync;
    logic [2:0]           hist;
    logic                 maj;
    logic                 is_break;
    logic                 done;
    logic                 fe_now;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync <= '1;
            hist <= '1;
        end else begin
            sync <= {sync[0], i_rx};
            hist <= {hist[1:0], sync[1]};
        end
    end

    assign maj      = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign is_break = (shreg == '0) && (PARITY == 0 || !pbit) && !maj;

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        done   = 1'b0;
        fe_now = ~maj;
        if (baud_cnt == '0) begin
            if (state == S_STOP1 && !is_break && STOP_BITS == 1) begin
                done = 1'b1;
            end else if (state == S_STOP2) begin
                done   = 1'b1;
                fe_now = ferr | ~maj;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            pbit     <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            o_break  <= 1'b0;
        end else begin
            o_break <= 1'b0;
            if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!hist[0]) begin
                            baud_cnt <= HALF;
                            pbit     <= 1'b0;
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                            state    <= S_START;
                        end
                    end
                    S_START: begin
                        if (maj) begin
                            state <= S_IDLE;
                        end else begin
                            baud_cnt <= FULL;
                            bit_idx  <= '0;
                            state    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        shreg    <= {maj, shreg[DATA_BITS-1:1]};
                        baud_cnt <= FULL;
                        if (bit_idx == LAST_BIT) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        pbit     <= maj;
                        perr     <= (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
                        baud_cnt <= FULL;
                        state    <= S_STOP1;
                    end
                    S_STOP1: begin
                        // An all-zero frame with a low stop sample is a held-low line, not data.
                        if (is_break) begin
                            o_break <= 1'b1;
                            state   <= S_BRKWAIT;
                        end else if (STOP_BITS == 2) begin
                            ferr     <= ~maj;
                            baud_cnt <= FULL;
                            state    <= S_STOP2;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_STOP2:   state <= S_IDLE;
                    S_BRKWAIT: if (hist[0]) state <= S_IDLE;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end

    // Holding register: a completing word may replace one being consumed in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (done) begin
                if (!o_valid || i_ready) begin
                    o_valid      <= 1'b1;
                    o_data       <= shreg;
                    o_frame_err  <= fe_now;
                    o_parity_err <= perr;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_rx_cfg.sv
`timescale 1ns/1ps
// Directed bench for serial_rx_cfg. Instances: 0 default 8N1 (416 clk/bit), 1 even parity,
// 2 odd parity, 3 fast 8N1, 4 two stop bits; instances 1..4 run at 16 clk/bit.
module tb_serial_rx_cfg;
    localparam int N_INST = 5;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx    [N_INST];
    logic       ready [N_INST];
    logic       valid [N_INST];
    logic [7:0] data  [N_INST];
    logic       fe    [N_INST];
    logic       pe    [N_INST];
    logic       brk   [N_INST];
    logic       ovr   [N_INST];

    int n_cmp = 0;
    int n_err = 0;

    int         acc_cnt  [N_INST] = '{default: 0};
    int         ovr_cnt  [N_INST] = '{default: 0};
    int         brk_cnt  [N_INST] = '{default: 0};
    logic [7:0] acc_data [N_INST];
    logic       acc_fe   [N_INST];
    logic       acc_pe   [N_INST];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        serial_rx_cfg #(
            .CLK_FREQ  ((g == 0) ? 48_000_000 : 1_600_000),
            .BAUD_RATE ((g == 0) ? 115_200 : 100_000),
            .DATA_BITS (8),
            .PARITY    ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
            .STOP_BITS ((g == 4) ? 2 : 1)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_rx         (rx[g]),
            .o_valid      (valid[g]),
            .i_ready      (ready[g]),
            .o_data       (data[g]),
            .o_frame_err  (fe[g]),
            .o_parity_err (pe[g]),
            .o_break      (brk[g]),
            .o_overrun    (ovr[g])
        );
    end

    // Handshake/pulse monitor sampling pre-edge values at each active edge.
    always @(posedge clk) begin
        for (int i = 0; i < N_INST; i++) begin
            if (valid[i] === 1'b1 && ready[i] === 1'b1) begin
                acc_cnt[i]  <= acc_cnt[i] + 1;
                acc_data[i] <= data[i];
                acc_fe[i]   <= fe[i];
                acc_pe[i]   <= pe[i];
            end
            if (ovr[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
            if (brk[i] === 1'b1) brk_cnt[i] <= brk_cnt[i] + 1;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got no end of test, required finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    function automatic int bc_of(input int inst);
        return (inst == 0) ? 416 : 16;
    endfunction

    function automatic int par_of(input int inst);
        return (inst == 1) ? 2 : ((inst == 2) ? 1 : 0);
    endfunction

    function automatic int stops_of(input int inst);
        return (inst == 4) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input int inst, input logic b);
        rx[inst] = b;
        repeat (bc_of(inst)) @(negedge clk);
    endtask

    task automatic send_frame(input int inst, input logic [7:0] d, input logic pbit,
                              input logic s1, input logic s2);
        send_bit(inst, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(inst, d[i]);
        if (par_of(inst) != 0) send_bit(inst, pbit);
        send_bit(inst, s1);
        if (stops_of(inst) == 2) send_bit(inst, s2);
        rx[inst] = 1'b1;
    endtask

    task automatic wait_word(input int inst, input int snap, input string name);
        int budget = 2 * bc_of(inst);
        while (acc_cnt[inst] == snap && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({name, " delivered"}, 32'(acc_cnt[inst] - snap), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int snap = acc_cnt[v.inst];
        ready[v.inst] = 1'b1;
        send_frame(v.inst, v.data, v.pbit, v.s1, v.s2);
        wait_word(v.inst, snap, name);
        check({name, " data"},      32'(acc_data[v.inst]), 32'(v.exp_data));
        check({name, " frame_err"}, 32'(acc_fe[v.inst]),   32'(v.exp_fe));
        check({name, " parity_err"}, 32'(acc_pe[v.inst]),  32'(v.exp_pe));
    endtask

    initial begin
        vec_t       vecs [11];
        int         snap_a;
        int         snap_b;
        logic [7:0] rd;

        //            inst  data   pbit  s1    s2    exp    fe    pe
        vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
        vecs[2]  = '{1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[3]  = '{2, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
        vecs[4]  = '{2, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[5]  = '{1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6]  = '{4, 8'hC3, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};
        vecs[7]  = '{4, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[8]  = '{3, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[9]  = '{3, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[10] = '{2, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1};

        for (int i = 0; i < N_INST; i++) begin
            rx[i]    = 1'b1;
            ready[i] = 1'b1;
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("reset inst%0d valid", i),      32'(valid[i]), 32'd0);
            check($sformatf("reset inst%0d data", i),       32'(data[i]),  32'd0);
            check($sformatf("reset inst%0d frame_err", i),  32'(fe[i]),    32'd0);
            check($sformatf("reset inst%0d parity_err", i), 32'(pe[i]),    32'd0);
            check($sformatf("reset inst%0d break_pulses", i),   32'(brk_cnt[i]), 32'd0);
            check($sformatf("reset inst%0d overrun_pulses", i), 32'(ovr_cnt[i]), 32'd0);
        end

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Short low glitch on the default-rate line must be rejected at the start check.
        snap_a = acc_cnt[0];
        snap_b = brk_cnt[0];
        rx[0] = 1'b0;
        repeat (100) @(negedge clk);
        rx[0] = 1'b1;
        repeat (600) @(negedge clk);
        check("glitch no word",  32'(acc_cnt[0] - snap_a), 32'd0);
        check("glitch no break", 32'(brk_cnt[0] - snap_b), 32'd0);
        check("glitch valid",    32'(valid[0]), 32'd0);
        run_vec('{0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0}, "after glitch");

        // 0x00 with a 1-cycle spike in bit 3 placed so that it is h0 at the sample edge.
        snap_a = acc_cnt[0];
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b0);
        rx[0] = 1'b0;
        repeat (bc_of(0) / 2 + 1) @(negedge clk);
        rx[0] = 1'b1;
        @(negedge clk);
        rx[0] = 1'b0;
        repeat (bc_of(0) - bc_of(0) / 2 - 2) @(negedge clk);
        for (int i = 4; i < 8; i++) send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        wait_word(0, snap_a, "spike");
        check("spike data", 32'(acc_data[0]), 32'h00);

        // Overrun: two back-to-back words with the consumer stalled.
        ready[3] = 1'b0;
        snap_a = acc_cnt[3];
        snap_b = ovr_cnt[3];
        send_frame(3, 8'h11, 1'b0, 1'b1, 1'b1);
        send_frame(3, 8'h22, 1'b0, 1'b1, 1'b1);
        repeat (32) @(negedge clk);
        check("overrun held valid",   32'(valid[3]), 32'd1);
        check("overrun held data",    32'(data[3]),  32'h11);
        check("overrun pulse count",  32'(ovr_cnt[3] - snap_b), 32'd1);
        check("overrun none taken",   32'(acc_cnt[3] - snap_a),  32'd0);
        ready[3] = 1'b1;
        @(negedge clk);
        ready[3] = 1'b0;
        check("consume valid drops",  32'(valid[3]), 32'd0);
        check("consume data holds",   32'(data[3]),  32'h11);
        check("consume taken word",   32'(acc_data[3]), 32'h11);

        // Consume coinciding with completion: ready high only at the STOP1 edge of 0x22.
        send_frame(3, 8'h33, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("coincide first held", 32'(data[3]), 32'h33);
        snap_a = acc_cnt[3];
        snap_b = ovr_cnt[3];
        fork
            send_frame(3, 8'h22, 1'b0, 1'b1, 1'b1);
            begin
                repeat (bc_of(3) / 2 + 4 + 9 * bc_of(3)) @(negedge clk);
                ready[3] = 1'b1;
                @(negedge clk);
                ready[3] = 1'b0;
            end
        join
        check("coincide taken count", 32'(acc_cnt[3] - snap_a), 32'd1);
        check("coincide taken word",  32'(acc_data[3]), 32'h33);
        check("coincide new valid",   32'(valid[3]), 32'd1);
        check("coincide new data",    32'(data[3]),  32'h22);
        check("coincide no overrun",  32'(ovr_cnt[3] - snap_b), 32'd0);
        ready[3] = 1'b1;
        repeat (2) @(negedge clk);
        check("coincide final word",  32'(acc_data[3]), 32'h22);

        // Line held low for 20 bit times: one break pulse, no word.
        snap_a = acc_cnt[0];
        snap_b = brk_cnt[0];
        rx[0] = 1'b0;
        repeat (20 * bc_of(0)) @(negedge clk);
        rx[0] = 1'b1;
        repeat (2 * bc_of(0)) @(negedge clk);
        check("break pulse count", 32'(brk_cnt[0] - snap_b), 32'd1);
        check("break no word",     32'(acc_cnt[0] - snap_a),  32'd0);
        check("break valid",       32'(valid[0]), 32'd0);
        run_vec('{0, 8'h7E, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0}, "after break");

        // Reset asserted on the DATA(4) sample edge of a 0x5A frame on the 2-stop instance.
        rd = 8'h5A;
        snap_a = acc_cnt[4];
        send_bit(4, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(4, rd[i]);
        rx[4] = rd[4];
        repeat (bc_of(4) / 2 + 4) @(negedge clk);
        rst = 1'b1;
        rx[4] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset valid",      32'(valid[4]), 32'd0);
        check("midreset data",       32'(data[4]),  32'd0);
        check("midreset frame_err",  32'(fe[4]),    32'd0);
        check("midreset parity_err", 32'(pe[4]),    32'd0);
        check("midreset break",      32'(brk[4]),   32'd0);
        check("midreset overrun",    32'(ovr[4]),   32'd0);
        repeat (3 * bc_of(4)) @(negedge clk);
        check("midreset no word", 32'(acc_cnt[4] - snap_a), 32'd0);
        run_vec('{4, 8'h81, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0}, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
